dmem_access: RTL and testbench

MEM-stage data-memory initiator for the 5-stage pipeline CPU. It accepts load/store requests from the pipeline and serves loads from a small direct-mapped, write-through, write-allocate cache of one-word lines. It drives the word-wide simple memory port on misses and stores, modelling a fixed memory latency with an internal counter. While the backing memory is busy it holds the pipeline with `stall`.

---
 rtl/dmem_access.sv | 136 +++++++++++++
 tb/tb_dmem_access.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access.sv
// MEM-stage data-memory initiator: direct-mapped, write-through, write-allocate
// cache of one-word lines in front of a fixed-latency word-wide memory port.
module dmem_access #(
  parameter int LINES   = 16,
  parameter int MEM_LAT = 4
) (
  input  logic        clock_me,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_wmem,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  output logic [1:0]  fsm_state
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;
  localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RWAIT = 2'd1;
  localparam logic [1:0] S_WWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Handshake: the CPU holds req/we/addr/wdata stable while stall=1; the
  // request retires in the first cycle with req=1 and stall=0, where rdata is valid.
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [29:0]      a_q;
  logic [31:0]      w_q;
  logic [31:0]      r_q;
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX-1:0] idx;
  logic [IDX-1:0] a_idx;
  logic [TW-1:0]  tag;
  logic [TW-1:0]  a_tag;
  logic           hit;
  logic           busy;
  logic           fill_rd;
  logic           fill_wr;
  logic           unused_bits;

  assign idx         = addr[2+IDX-1:2];
  assign tag         = addr[31:2+IDX];
  assign a_idx       = a_q[IDX-1:0];
  assign a_tag       = a_q[29:IDX];
  assign hit         = valid[idx] && (tag_mem[idx] == tag);
  assign busy        = (state == S_RWAIT) || (state == S_WWAIT);
  assign fill_rd     = (state == S_RWAIT) && (cnt == '0);
  assign fill_wr     = (state == S_WWAIT) && (cnt == '0);
  assign unused_bits = &{1'b0, addr[1:0]};

  // The write strobe is derived from state, so an asserted reset removes it at once.
  assign mem_wmem  = fill_wr;
  assign mem_addr  = busy ? {a_q, 2'b00} : {addr[31:2], 2'b00};
  assign mem_in    = w_q;
  assign fsm_state = state;

  always_comb begin
    stall = 1'b0;
    rdata = '0;
    case (state)
      S_IDLE: begin
        stall = req && (we || !hit);
        if (req && !we && hit) rdata = data_mem[idx];
      end
      S_RWAIT, S_WWAIT: stall = 1'b1;
      S_DONE:           rdata = r_q;
      default:          ;
    endcase
  end

  always_ff @(posedge clock_me or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      w_q   <= '0;
      r_q   <= '0;
      valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && we) begin
            a_q   <= addr[31:2];
            w_q   <= wdata;
            cnt   <= CNT_LOAD;
            state <= S_WWAIT;
          end else if (req && !hit) begin
            a_q   <= addr[31:2];
            cnt   <= CNT_LOAD;
            state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (cnt == '0) begin
            valid[a_idx] <= 1'b1;
            r_q          <= mem_out;
            state        <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WWAIT: begin
          if (cnt == '0) begin
            valid[a_idx] <= 1'b1;
            state        <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays need no reset: a line is only trusted through its valid bit.
  always_ff @(posedge clock_me) begin
    if (fill_rd) begin
      tag_mem[a_idx]  <= a_tag;
      data_mem[a_idx] <= mem_out;
    end else if (fill_wr) begin
      tag_mem[a_idx]  <= a_tag;
      data_mem[a_idx] <= w_q;
    end
  end
endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: two instances (MEM_LAT=4 and MEM_LAT=1), each with its
// own behavioural memory, cache model and per-cycle expectation queue.
module tb_dmem_access;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req, we, stall, mem_wmem;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_in [2];
  logic [31:0] mem_out [2];
  logic [1:0]  fsm_state [2];

  dmem_access #(.LINES(16), .MEM_LAT(4)) u_dut0 (
    .clock_me(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .stall(stall[0]), .mem_addr(mem_addr[0]),
    .mem_wmem(mem_wmem[0]), .mem_in(mem_in[0]), .mem_out(mem_out[0]),
    .fsm_state(fsm_state[0])
  );

  dmem_access #(.LINES(16), .MEM_LAT(1)) u_dut1 (
    .clock_me(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .stall(stall[1]), .mem_addr(mem_addr[1]),
    .mem_wmem(mem_wmem[1]), .mem_in(mem_in[1]), .mem_out(mem_out[1]),
    .fsm_state(fsm_state[1])
  );

  int n_checks = 0;
  int n_err    = 0;

  // Backing memory: untouched words read a fixed pattern, written words read back.
  logic [31:0] hw_data [2][1024];
  bit          hw_wr   [2][1024];
  int          wr_cnt  [2];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[11:2] == 10'h010) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {20'h0, a[11:2], 2'b00};
  endfunction

  assign mem_out[0] = hw_wr[0][mem_addr[0][11:2]] ? hw_data[0][mem_addr[0][11:2]] : init_word(mem_addr[0]);
  assign mem_out[1] = hw_wr[1][mem_addr[1][11:2]] ? hw_data[1][mem_addr[1][11:2]] : init_word(mem_addr[1]);

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_wmem[k] === 1'b1) begin
        hw_data[k][mem_addr[k][11:2]] <= mem_in[k];
        hw_wr[k][mem_addr[k][11:2]]   <= 1'b1;
        wr_cnt[k]                     <= wr_cnt[k] + 1;
      end
    end
  end

  // Reference model: what memory should hold and which lines the cache holds.
  logic [31:0] ref_data [2][1024];
  bit          ref_wr   [2][1024];
  bit          mv       [2][16];
  logic [25:0] mtag     [2][16];
  int          exp_wr   [2];

  function automatic logic [31:0] ref_rd(input int k, input logic [31:0] a);
    return ref_wr[k][a[11:2]] ? ref_data[k][a[11:2]] : init_word(a);
  endfunction

  // Expectation entry: {stall, mem_wmem, rdata_check, data, mem_addr}.
  logic [66:0] exp_q0 [$];
  logic [66:0] exp_q1 [$];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int k);
    logic [66:0] e;
    bit have;
    have = 1'b0;
    e    = '0;
    if (k == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
    if (k == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
    if (have) begin
      chk("stall", k, {31'b0, stall[k]}, {31'b0, e[66]});
      chk("mem_wmem", k, {31'b0, mem_wmem[k]}, {31'b0, e[65]});
      if (e[65]) begin
        chk("mem_addr", k, mem_addr[k], e[31:0]);
        chk("mem_in", k, mem_in[k], e[63:32]);
      end
      if (e[64]) chk("rdata", k, rdata[k], e[63:32]);
    end else begin
      chk("idle_stall", k, {31'b0, stall[k]}, 32'd0);
      chk("idle_wmem", k, {31'b0, mem_wmem[k]}, 32'd0);
      chk("idle_mem_addr", k, mem_addr[k], {addr[k][31:2], 2'b00});
    end
  endtask

  always @(negedge clk) begin
    cmp_one(0);
    cmp_one(1);
  end

  int          obs_stalls;
  int          obs_writes;
  logic [31:0] obs_rdata;

  task automatic push_exp(input int k, input logic [66:0] e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // One access, starting just after a rising edge; returns just after the retiring edge.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    int lat, n, idx, wr0;
    logic [25:0] tg;
    logic [31:0] ed;
    bit hit;
    lat = (k == 0) ? 4 : 1;
    idx = int'(a[5:2]);
    tg  = a[31:6];
    hit = !w && mv[k][idx] && (mtag[k][idx] == tg);
    ed  = w ? d : ref_rd(k, a);
    n   = hit ? 1 : lat + 2;
    for (int c = 0; c < n; c++)
      push_exp(k, {(c < n - 1), (w && c == lat), (!w && c == n - 1), ed, {a[31:2], 2'b00}});
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    wr0 = wr_cnt[k];
    obs_stalls = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (stall[k]) obs_stalls++;
      obs_rdata = rdata[k];
      @(posedge clk);
      #1;
    end
    req[k] = 1'b0; we[k] = 1'b0;
    obs_writes = wr_cnt[k] - wr0;
    if (w) begin
      ref_data[k][a[11:2]] = d;
      ref_wr[k][a[11:2]]   = 1'b1;
      exp_wr[k]++;
    end
    if (w || !hit) begin
      mv[k][idx]   = 1'b1;
      mtag[k][idx] = tg;
    end
  endtask

  task automatic pin(input string name, input int k, input int st, input logic [31:0] rd, input bit chk_rd);
    chk({name, "_stalls"}, k, 32'(obs_stalls), 32'(st));
    if (chk_rd) chk({name, "_rdata"}, k, obs_rdata, rd);
  endtask

  // Store on dut0 cut short by reset in the cycle its write strobe is up.
  task automatic aborted_store(input logic [31:0] a, input logic [31:0] d);
    int wr0;
    for (int c = 0; c < 4; c++) push_exp(0, {1'b1, 1'b0, 1'b0, d, {a[31:2], 2'b00}});
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = a; wdata[0] = d;
    wr0 = wr_cnt[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      @(posedge clk);
    end
    #1;
    chk("wmem_before_abort", 0, {31'b0, mem_wmem[0]}, 32'd1);
    rst[0] = 1'b1; req[0] = 1'b0; we[0] = 1'b0;
    #1;
    chk("abort_wmem_async", 0, {31'b0, mem_wmem[0]}, 32'd0);
    chk("abort_stall", 0, {31'b0, stall[0]}, 32'd0);
    for (int i = 0; i < 16; i++) mv[0][i] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    chk("abort_no_write", 0, 32'(wr_cnt[0] - wr0), 32'd0);
    chk("abort_mem_untouched", 0, {31'b0, hw_wr[0][a[11:2]]}, 32'd0);
  endtask

  initial begin
    rst = 2'b11; req = 2'b00; we = 2'b00;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0; exp_wr[k] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", k, rdata[k], 32'd0);
      chk("reset_state", k, {30'b0, fsm_state[k]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 2'b00;

    // Fill, then hit.
    access(0, 1'b0, 32'h40, 32'h0);          pin("miss_0x40", 0, 5, 32'hDEADBEEF, 1'b1);
    access(0, 1'b0, 32'h40, 32'h0);          pin("hit_0x40", 0, 0, 32'hDEADBEEF, 1'b1);
    // Store, then load of the same word hits.
    access(0, 1'b1, 32'h80, 32'h12345678);   pin("store_0x80", 0, 5, 32'h0, 1'b0);
    chk("store_0x80_writes", 0, 32'(obs_writes), 32'd1);
    chk("store_0x80_mem", 0, hw_data[0][10'h020], 32'h12345678);
    access(0, 1'b0, 32'h80, 32'h0);          pin("hit_0x80", 0, 0, 32'h12345678, 1'b1);
    // Index conflict between 0x000 and 0x040.
    access(0, 1'b0, 32'h000, 32'h0);         pin("conf_a", 0, 5, 32'hC0DE0000, 1'b1);
    access(0, 1'b0, 32'h040, 32'h0);         pin("conf_b", 0, 5, 32'hDEADBEEF, 1'b1);
    access(0, 1'b0, 32'h000, 32'h0);         pin("conf_a_again", 0, 5, 32'hC0DE0000, 1'b1);
    // Byte offset bits are ignored.
    access(0, 1'b0, 32'h040, 32'h0);         pin("refill_0x40", 0, 5, 32'hDEADBEEF, 1'b1);
    access(0, 1'b0, 32'h043, 32'h0);         pin("unaligned_0x43", 0, 0, 32'hDEADBEEF, 1'b1);
    // Reset during a store: no write, cache invalidated.
    aborted_store(32'hC4, 32'hCAFEF00D);
    access(0, 1'b0, 32'hC4, 32'h0);          pin("after_abort_0xC4", 0, 5, 32'hC0DE00C4, 1'b1);
    access(0, 1'b0, 32'h80, 32'h0);          pin("after_abort_0x80", 0, 5, 32'h12345678, 1'b1);

    // MEM_LAT=1: alternating stores and conflicting loads.
    for (int i = 0; i < 4; i++) begin
      access(1, 1'b1, 32'h100 + 32'(8 * i), 32'h10000000 + 32'(i * 32'h111));
      pin("lat1_store", 1, 2, 32'h0, 1'b0);
      chk("lat1_store_writes", 1, 32'(obs_writes), 32'd1);
      access(1, 1'b0, 32'h200 + 32'(8 * i), 32'h0);
      pin("lat1_load", 1, 2, 32'hC0DE0200 + 32'(8 * i), 1'b1);
    end
    access(1, 1'b1, 32'h300, 32'hA5A55A5A);  pin("lat1_store_0x300", 1, 2, 32'h0, 1'b0);
    access(1, 1'b0, 32'h300, 32'h0);         pin("lat1_hit_0x300", 1, 0, 32'hA5A55A5A, 1'b1);

    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("total_writes", k, 32'(wr_cnt[k]), 32'(exp_wr[k]));
      for (int w = 0; w < 1024; w++)
        if (ref_wr[k][w]) chk("mem_contents", k, hw_data[k][w], ref_data[k][w]);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
